// File: rtl/led_blink_bank_pkg.sv
// Shared types for the LED blink bank: drive modes and per-channel configuration.
package led_blink_pkg;

    localparam int unsigned DIV_MAX_W = 32;
    localparam int unsigned PWM_MAX_W = 16;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    // Fields are sized for the widest supported channel; narrower instances zero-extend.
    typedef struct packed {
        mode_e                 mode;
        logic [DIV_MAX_W-1:0]  div;
        logic [PWM_MAX_W-1:0]  duty;
    } ch_cfg_t;

endpackage

// File: rtl/led_blink_bank_if.sv
// Configuration write port of the LED blink bank (valid/ready plus error pulse).
interface led_blink_bank_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned PWM_W    = 4
);
    localparam int unsigned CH_W = $clog2(CHANNELS) + 1;

    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [1:0]        cfg_mode;
    logic [DIV_W-1:0]  cfg_div;
    logic [PWM_W-1:0]  cfg_duty;
    logic              cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_div, cfg_duty,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_div, cfg_duty,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/led_blink_channel.sv
// One LED channel: config registers, prescaler, phase counter, tick and registered drive.
module led_blink_channel
    import led_blink_pkg::*;
#(
    parameter int unsigned      DIV_W     = 16,
    parameter int unsigned      CNT_W     = 8,
    parameter int unsigned      PWM_W     = 4,
    parameter logic [DIV_W-1:0] DIV_RESET = 16'hFFFF
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    wr,
    input  ch_cfg_t cfg_in,
    output logic    tick,
    output logic    d
);

    ch_cfg_t          cfg_q;
    logic [DIV_W-1:0] p;
    logic [CNT_W-1:0] c;
    logic             wrap;
    logic             d_next;

    assign wrap = (DIV_MAX_W'(p) == cfg_q.div);

    always_comb begin
        d_next = 1'b0;
        unique case (cfg_q.mode)
            MODE_OFF:   d_next = 1'b0;
            MODE_ON:    d_next = 1'b1;
            MODE_BLINK: d_next = c[CNT_W-1];
            MODE_PWM:   d_next = (PWM_MAX_W'(c[PWM_W-1:0]) < cfg_q.duty);
        endcase
    end

    // A write takes priority over a wrap on the same edge, so a restart never ticks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cfg_q <= '{mode: MODE_BLINK, div: DIV_MAX_W'(DIV_RESET), duty: '0};
            p     <= '0;
            c     <= '0;
            tick  <= 1'b0;
            d     <= 1'b0;
        end else begin
            d <= d_next;
            if (wr) begin
                cfg_q <= cfg_in;
                p     <= '0;
                c     <= '0;
                tick  <= 1'b0;
            end else if (wrap) begin
                p     <= '0;
                c     <= c + 1'b1;
                tick  <= 1'b1;
            end else begin
                p     <= p + 1'b1;
                tick  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/led_blink_bank.sv
// Bank of independent LED channels with a shared config write port and replicated pin groups.
module led_blink_bank
    import led_blink_pkg::*;
#(
    parameter int unsigned      CHANNELS    = 4,
    parameter int unsigned      LEDS_PER_CH = 2,
    parameter int unsigned      DIV_W       = 16,
    parameter int unsigned      CNT_W       = 8,
    parameter int unsigned      PWM_W       = 4,
    parameter logic [DIV_W-1:0] DIV_RESET   = 16'hFFFF
) (
    input  logic                            clk,
    input  logic                            rst,
    led_blink_bank_if.slave                 cfg,
    output logic [CHANNELS-1:0]             tick,
    output logic [CHANNELS*LEDS_PER_CH-1:0] led
);

    logic                accept;
    logic                ch_ok;
    logic [CHANNELS-1:0] wr;
    logic [CHANNELS-1:0] d;
    ch_cfg_t             cfg_in;

    assign accept = cfg.cfg_valid & cfg.cfg_ready;
    assign ch_ok  = (32'(cfg.cfg_ch) < CHANNELS);
    assign cfg_in = '{mode: mode_e'(cfg.cfg_mode),
                      div:  DIV_MAX_W'(cfg.cfg_div),
                      duty: PWM_MAX_W'(cfg.cfg_duty)};

    always_comb begin
        wr = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            wr[i] = accept && (32'(cfg.cfg_ch) == i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cfg.cfg_ready <= 1'b0;
            cfg.cfg_err   <= 1'b0;
        end else begin
            cfg.cfg_ready <= 1'b1;
            cfg.cfg_err   <= accept & ~ch_ok;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        led_blink_channel #(
            .DIV_W     (DIV_W),
            .CNT_W     (CNT_W),
            .PWM_W     (PWM_W),
            .DIV_RESET (DIV_RESET)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .wr     (wr[g]),
            .cfg_in (cfg_in),
            .tick   (tick[g]),
            .d      (d[g])
        );
    end

    always_comb begin
        led = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            led[i*LEDS_PER_CH +: LEDS_PER_CH] = {LEDS_PER_CH{d[i]}};
        end
    end

endmodule
